// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin lock scheduler: state encoding,
// default sizing and a width helper.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int DEFAULT_PORT     = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int sched_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// Combinational fixed-priority pick: the lowest set request bit wins,
// output is one-hot or zero.
module fixed_priority_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] gnt
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/rr_lock_scheduler.sv
// Round-robin scheduler granting one multi-cycle resource to one requester at a
// time, with hold limit, release strobe and a one-cycle dead gap between owners.
module rr_lock_scheduler
    import rr_sched_pkg::*;
#(
    parameter int PORT     = DEFAULT_PORT,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PORT-1:0]         req,
    // Release strobe from the current owner ("release" is a reserved word).
    input  logic [PORT-1:0]         rel,
    output logic [PORT-1:0]         grant,
    output logic [$clog2(PORT)-1:0] owner_id,
    output logic                    busy,
    output logic                    timeout
);

    localparam int IDW = sched_clog2(PORT);
    localparam int HCW = sched_clog2(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(PORT - 1);

    sched_state_t   state_reg, state_next;
    logic [PORT-1:0] grant_reg, grant_next;
    logic [IDW-1:0]  owner_reg, owner_next;
    logic [IDW-1:0]  last_owner_reg, last_owner_next;
    logic [HCW-1:0]  hold_cnt_reg, hold_cnt_next;
    logic            busy_reg, busy_next;
    logic            timeout_reg, timeout_next;

    logic [PORT-1:0] mask;
    logic [PORT-1:0] masked_req;
    logic [PORT-1:0] gnt_masked;
    logic [PORT-1:0] gnt_raw;
    logic [PORT-1:0] win_onehot;
    logic [IDW-1:0]  win_idx;
    logic            owner_done;

    // Ports strictly above the previous owner get first look.
    for (genvar gi = 0; gi < PORT; gi++) begin : g_mask
        assign mask[gi] = (gi > int'(last_owner_reg));
    end

    assign masked_req = req & mask;

    fixed_priority_arbiter #(.WIDTH(PORT)) u_arb_masked (
        .req (masked_req),
        .gnt (gnt_masked)
    );

    fixed_priority_arbiter #(.WIDTH(PORT)) u_arb_raw (
        .req (req),
        .gnt (gnt_raw)
    );

    assign win_onehot = (|masked_req) ? gnt_masked : gnt_raw;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < PORT; i++) begin
            if (win_onehot[i]) begin
                win_idx = win_idx | IDW'(i);
            end
        end
    end

    assign owner_done = rel[owner_reg] | ~req[owner_reg];

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;
        busy_next       = busy_reg;
        timeout_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    grant_next      = win_onehot;
                    owner_next      = win_idx;
                    last_owner_next = win_idx;
                    hold_cnt_next   = '0;
                    busy_next       = 1'b1;
                    state_next      = ST_OWN;
                end
            end
            ST_OWN: begin
                // A release wins over the hold limit, so timeout stays low then.
                if (owner_done || (hold_cnt_reg == HOLD_LAST)) begin
                    grant_next   = '0;
                    owner_next   = '0;
                    busy_next    = 1'b0;
                    timeout_next = ~owner_done;
                    state_next   = ST_GAP;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HCW'(1);
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                grant_next = '0;
                owner_next = '0;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_owner_reg <= LAST_INIT;
            hold_cnt_reg   <= '0;
            busy_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
            busy_reg       <= busy_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign grant    = grant_reg;
    assign owner_id = owner_reg;
    assign busy     = busy_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_rr_lock_scheduler.sv
// Directed and randomized bench for rr_lock_scheduler against a tenure-level
// reference model (owner, cycles held, remaining dead cycles, rotation search).
module tb_rr_lock_scheduler;

    localparam int PORT     = 4;
    localparam int MAX_HOLD = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req   = 4'b0;
    logic [3:0] rel   = 4'b0;
    logic [3:0] grant;
    logic [1:0] owner_id;
    logic       busy;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_owner;
    int m_tenure;
    int m_dead;
    int m_last;
    bit m_timeout;

    logic [3:0] prev_grant = 4'b0;
    logic [3:0] starts[$];

    always #5 clk = ~clk;

    rr_lock_scheduler #(.PORT(PORT), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .rel      (rel),
        .grant    (grant),
        .owner_id (owner_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    task automatic model_reset();
        m_owner   = -1;
        m_tenure  = 0;
        m_dead    = 0;
        m_last    = PORT - 1;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge();
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            if (rel[m_owner] || !req[m_owner]) begin
                m_owner = -1;
                m_dead  = 1;
            end else if (m_tenure == MAX_HOLD) begin
                m_owner   = -1;
                m_dead    = 1;
                m_timeout = 1'b1;
            end else begin
                m_tenure++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if (req != 4'b0) begin
            for (int k = 1; k <= PORT; k++) begin
                int p;
                p = (m_last + k) % PORT;
                if (req[p] && m_owner < 0) m_owner = p;
            end
            m_tenure = 1;
            m_last   = m_owner;
        end
    endtask

    task automatic check(input string tag);
        logic [3:0] eg;
        logic [1:0] eo;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        eo = (m_owner >= 0) ? 2'(m_owner) : 2'b0;
        n_assert++;
        assert (grant === eg) else begin
            n_fail++;
            $error("FAIL %s grant observed=%b expected=%b", tag, grant, eg);
        end
        n_assert++;
        assert (owner_id === eo) else begin
            n_fail++;
            $error("FAIL %s owner_id observed=%0d expected=%0d", tag, owner_id, eo);
        end
        n_assert++;
        assert (busy === (m_owner >= 0)) else begin
            n_fail++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, (m_owner >= 0));
        end
        n_assert++;
        assert (timeout === m_timeout) else begin
            n_fail++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, timeout, m_timeout);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        check(tag);
        if (grant != 4'b0 && prev_grant == 4'b0) starts.push_back(grant);
        prev_grant = grant;
        $display("cyc=%0d %s req=%b rel=%b grant=%b id=%0d busy=%b to=%b",
                 cyc, tag, req, rel, grant, owner_id, busy, timeout);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0;
        rel   = 4'b0;
        #1;
        model_reset();
        check("reset");
        #1;
        reset = 1'b1;
        starts.delete();
        prev_grant = 4'b0;
    endtask

    task automatic expect_val(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Pulse release on the owner's second cycle.
    task automatic rel_after_two();
        rel = (m_owner >= 0 && m_tenure == 2) ? 4'(1 << m_owner) : 4'b0;
    endtask

    initial begin
        logic [3:0] order_exp [5];
        int run_len;
        int first_run;
        int to_seen;

        model_reset();
        #12;
        check("reset_init");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Full rotation with two-cycle tenures.
        do_reset();
        req = 4'b1111;
        repeat (22) begin
            rel_after_two();
            tick("rotate");
        end
        rel = 4'b0;
        order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        expect_val("rotate_count", (starts.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < starts.size(); i++) begin
            expect_val($sformatf("rotate_order%0d", i), int'(starts[i]), int'(order_exp[i]));
        end

        // Single requester runs into the hold limit and is re-granted.
        do_reset();
        req = 4'b0100;
        run_len = 0; first_run = -1; to_seen = 0;
        repeat (40) begin
            tick("hold_limit");
            if (grant == 4'b0100) run_len++;
            if (timeout) begin
                to_seen++;
                if (first_run < 0) first_run = run_len;
                run_len = 0;
            end
        end
        expect_val("hold_len", first_run, MAX_HOLD);
        expect_val("hold_regrant", (starts.size() >= 2) ? int'(starts[1]) : 0, 4'b0100);

        // Masked search then wrap to the unmasked side.
        do_reset();
        req = 4'b0010;
        tick("mask_start");
        req = 4'b1011;
        repeat (14) begin
            rel_after_two();
            tick("mask_rot");
        end
        rel = 4'b0;
        expect_val("mask_first", (starts.size() >= 3) ? int'(starts[0]) : 0, 4'b0010);
        expect_val("mask_next", (starts.size() >= 3) ? int'(starts[1]) : 0, 4'b1000);
        expect_val("mask_wrap", (starts.size() >= 3) ? int'(starts[2]) : 0, 4'b0001);

        // Release coincides with the hold limit: no timeout.
        do_reset();
        req = 4'b0001;
        to_seen = 0;
        repeat (20) begin
            rel = (m_owner == 0 && m_tenure == MAX_HOLD) ? 4'b0001 : 4'b0000;
            tick("rel_at_limit");
            if (timeout) to_seen++;
        end
        rel = 4'b0;
        expect_val("rel_at_limit_to", to_seen, 0);

        // Owner drops its request without a release pulse.
        do_reset();
        req = 4'b0100;
        repeat (3) tick("drop_hold");
        req = 4'b0000;
        repeat (4) tick("drop_gap");

        // Asynchronous reset mid-tenure.
        do_reset();
        req = 4'b0010;
        repeat (3) tick("pre_async");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        req = 4'b1010;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick("post_async");
        expect_val("post_async_grant", int'(grant), 4'b0010);

        // Randomized traffic.
        do_reset();
        repeat (500) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rel = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
